// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressable MIPS data memory for the MEM stage.
// Byte, halfword and word loads/stores with sign or zero extension and
// misalignment detection. Contents are cleared by a one-word-per-cycle sweep.
// A valid/ready dump port streams the contents to the debug unit in order.
module byte_data_memory #(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_flush,
   input  logic                   i_wr,
   input  logic [1:0]             i_access_size,
   input  logic                   i_sign_ext,
   input  logic [ADDR_SIZE+1:0]   i_addr,
   input  logic [WORD_SIZE-1:0]   i_data,
   output logic [WORD_SIZE-1:0]   o_data,
   output logic                   o_misaligned,
   output logic                   o_busy,
   input  logic                   i_dump_start,
   output logic [WORD_SIZE-1:0]   o_dump_data,
   output logic                   o_dump_valid,
   input  logic                   i_dump_ready,
   output logic                   o_dump_last
);

   localparam int DEPTH = 1 << ADDR_SIZE;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_CLEAR = 2'b01;
   localparam logic [1:0] ST_DUMP  = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   localparam logic [ADDR_SIZE-1:0] IDX_ZERO = {ADDR_SIZE{1'b0}};
   localparam logic [ADDR_SIZE-1:0] IDX_LAST = {ADDR_SIZE{1'b1}};
   localparam logic [ADDR_SIZE-1:0] IDX_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

   logic [WORD_SIZE-1:0] mem_r [0:DEPTH-1];

   logic [1:0]           state_r;
   logic [ADDR_SIZE-1:0] idx_r;
   logic                 busy_r;
   logic                 dump_valid_r;
   logic                 dump_last_r;

   logic [1:0]           state_nx_s;
   logic [ADDR_SIZE-1:0] idx_nx_s;

   logic [ADDR_SIZE-1:0] word_addr_s;
   logic [1:0]           lane_s;
   logic [31:0]          rd_word_s;
   logic [31:0]          rd_shift_s;
   logic [7:0]           rd_byte_s;
   logic [15:0]          rd_half_s;
   logic [31:0]          load_data_s;
   logic                 misaligned_s;
   logic [3:0]           lane_mask_s;
   logic [31:0]          bit_mask_s;
   logic [31:0]          wr_data_s;
   logic                 restart_s;
   logic                 store_we_s;
   logic                 clear_we_s;

   assign word_addr_s = i_addr[ADDR_SIZE+1:2];
   assign lane_s      = i_addr[1:0];
   assign rd_word_s   = mem_r[word_addr_s];
   assign restart_s   = i_reset | i_flush;

   // Misalignment depends only on access size and the low address bits.
   always_comb begin
      misaligned_s = 1'b0;
      case (i_access_size)
         SZ_BYTE: misaligned_s = 1'b0;
         SZ_HALF: misaligned_s = lane_s[0];
         default: misaligned_s = (lane_s != 2'b00);
      endcase
   end

   // Load path: pick the lane (aligned down) and extend it.
   always_comb begin
      rd_shift_s  = rd_word_s >> {lane_s, 3'b000};
      rd_byte_s   = rd_shift_s[7:0];
      rd_half_s   = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      load_data_s = rd_word_s;
      case (i_access_size)
         SZ_BYTE: begin
            if (i_sign_ext) begin
               load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            end else begin
               load_data_s = {24'h000000, rd_byte_s};
            end
         end
         SZ_HALF: begin
            if (i_sign_ext) begin
               load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
            end else begin
               load_data_s = {16'h0000, rd_half_s};
            end
         end
         default: load_data_s = rd_word_s;
      endcase
   end

   // Store path: lane enables and store data replicated into every lane.
   always_comb begin
      lane_mask_s = 4'b1111;
      wr_data_s   = i_data[31:0];
      case (i_access_size)
         SZ_BYTE: begin
            lane_mask_s = 4'b0001 << lane_s;
            wr_data_s   = {4{i_data[7:0]}};
         end
         SZ_HALF: begin
            lane_mask_s = lane_s[1] ? 4'b1100 : 4'b0011;
            wr_data_s   = {2{i_data[15:0]}};
         end
         default: begin
            lane_mask_s = 4'b1111;
            wr_data_s   = i_data[31:0];
         end
      endcase
      bit_mask_s = {{8{lane_mask_s[3]}}, {8{lane_mask_s[2]}},
                    {8{lane_mask_s[1]}}, {8{lane_mask_s[0]}}};
   end

   // Memory writes only happen from an undisturbed IDLE (stores) or CLEAR (sweep).
   always_comb begin
      store_we_s = (state_r == ST_IDLE) & i_wr & ~misaligned_s & ~restart_s;
      clear_we_s = (state_r == ST_CLEAR) & ~restart_s;
   end

   // Next state and sweep/dump index; reset and flush both restart the clear.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      if (restart_s) begin
         state_nx_s = ST_CLEAR;
         idx_nx_s   = IDX_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_dump_start) begin
                  state_nx_s = ST_DUMP;
                  idx_nx_s   = IDX_ZERO;
               end else begin
                  state_nx_s = ST_IDLE;
                  idx_nx_s   = idx_r;
               end
            end
            ST_CLEAR: begin
               if (idx_r == IDX_LAST) begin
                  state_nx_s = ST_IDLE;
                  idx_nx_s   = IDX_ZERO;
               end else begin
                  state_nx_s = ST_CLEAR;
                  idx_nx_s   = idx_r + IDX_ONE;
               end
            end
            ST_DUMP: begin
               if (i_dump_ready && (idx_r == IDX_LAST)) begin
                  state_nx_s = ST_IDLE;
                  idx_nx_s   = IDX_ZERO;
               end else if (i_dump_ready) begin
                  state_nx_s = ST_DUMP;
                  idx_nx_s   = idx_r + IDX_ONE;
               end else begin
                  state_nx_s = ST_DUMP;
                  idx_nx_s   = idx_r;
               end
            end
            default: begin
               state_nx_s = ST_CLEAR;
               idx_nx_s   = IDX_ZERO;
            end
         endcase
      end
   end

   // Control registers; status flags are registered from the next state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r      <= ST_CLEAR;
         idx_r        <= IDX_ZERO;
         busy_r       <= 1'b1;
         dump_valid_r <= 1'b0;
         dump_last_r  <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         idx_r        <= idx_nx_s;
         busy_r       <= (state_nx_s != ST_IDLE);
         dump_valid_r <= (state_nx_s == ST_DUMP);
         dump_last_r  <= (state_nx_s == ST_DUMP) && (idx_nx_s == IDX_LAST);
      end
   end

   // Memory array: sweep clears one word per cycle, stores merge the enabled lanes.
   always_ff @(posedge i_clk) begin
      if (clear_we_s) begin
         mem_r[idx_r] <= {WORD_SIZE{1'b0}};
      end else if (store_we_s) begin
         mem_r[word_addr_s] <= (rd_word_s & ~bit_mask_s) | (wr_data_s & bit_mask_s);
      end
   end

   assign o_data       = load_data_s;
   assign o_misaligned = misaligned_s;
   assign o_busy       = busy_r;
   assign o_dump_valid = dump_valid_r;
   assign o_dump_last  = dump_last_r;
   assign o_dump_data  = mem_r[idx_r];

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed self-checking bench for byte_data_memory (ADDR_SIZE = 5).
module tb_byte_data_memory;

   logic        clk;
   logic        i_reset;
   logic        i_flush;
   logic        i_wr;
   logic [1:0]  i_access_size;
   logic        i_sign_ext;
   logic [6:0]  i_addr;
   logic [31:0] i_data;
   logic [31:0] o_data;
   logic        o_misaligned;
   logic        o_busy;
   logic        i_dump_start;
   logic [31:0] o_dump_data;
   logic        o_dump_valid;
   logic        i_dump_ready;
   logic        o_dump_last;

   int tests = 0;
   int fails = 0;
   logic [31:0] model [32];

   byte_data_memory #(.ADDR_SIZE(5), .WORD_SIZE(32)) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_flush       (i_flush),
      .i_wr          (i_wr),
      .i_access_size (i_access_size),
      .i_sign_ext    (i_sign_ext),
      .i_addr        (i_addr),
      .i_data        (i_data),
      .o_data        (o_data),
      .o_misaligned  (o_misaligned),
      .o_busy        (o_busy),
      .i_dump_start  (i_dump_start),
      .o_dump_data   (o_dump_data),
      .o_dump_valid  (o_dump_valid),
      .i_dump_ready  (i_dump_ready),
      .o_dump_last   (o_dump_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [1:0] sz, input logic [6:0] addr, input logic [31:0] data);
      i_access_size = sz;
      i_addr        = addr;
      i_data        = data;
      i_wr          = 1'b1;
      tick();
      i_wr          = 1'b0;
   endtask

   task automatic dump_check(input bit send_start, input int mode, input string name);
      int k;
      k = 0;
      if (send_start) begin
         i_dump_start = 1'b1;
         tick();
         i_dump_start = 1'b0;
      end
      for (int cyc = 0; cyc < 200 && k < 32; cyc++) begin
         i_dump_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         #1;
         tests++;
         if (o_dump_valid !== 1'b1 || o_dump_data !== model[k] || o_dump_last !== (k == 31)) begin
            fails++;
            $display("FAIL %s word %0d: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     name, k, o_dump_valid, o_dump_data, o_dump_last, model[k], (k == 31));
         end
         if (i_dump_ready) k++;
         tick();
      end
      i_dump_ready = 1'b0;
      tests++;
      if (k != 32) begin
         fails++;
         $display("FAIL %s count: got %0d words, expected 32", name, k);
      end
      tests++;
      if (o_dump_valid !== 1'b0 || o_busy !== 1'b0 || o_dump_last !== 1'b0) begin
         fails++;
         $display("FAIL %s end: got valid=%b busy=%b last=%b, expected 0 0 0",
                  name, o_dump_valid, o_busy, o_dump_last);
      end
   endtask

   task automatic test_reset();
      int busy_cnt;
      i_reset = 1'b1;
      tick();
      tick();
      tests++;
      if (o_busy !== 1'b1 || o_dump_valid !== 1'b0 || o_dump_last !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got busy=%b valid=%b last=%b, expected 1 0 0",
                  o_busy, o_dump_valid, o_dump_last);
      end
      i_reset  = 1'b0;
      busy_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         if (o_busy !== 1'b1) break;
         busy_cnt++;
         tick();
      end
      tests++;
      if (busy_cnt != 32) begin
         fails++;
         $display("FAIL reset_sweep_len: got %0d busy cycles, expected 32", busy_cnt);
      end
      for (int w = 0; w < 32; w++) model[w] = 32'h00000000;
      dump_check(1'b1, 0, "zero_dump");
   endtask

   task automatic test_loads();
      logic [41:0] vec_a [4] = '{
         {2'b00, 7'h0B, 1'b0, 32'h00000011},
         {2'b00, 7'h08, 1'b1, 32'h00000044},
         {2'b00, 7'h09, 1'b1, 32'h00000033},
         {2'b11, 7'h08, 1'b0, 32'h11223344}};
      logic [41:0] vec_b [5] = '{
         {2'b01, 7'h0A, 1'b1, 32'hFFFF8001},
         {2'b01, 7'h0A, 1'b0, 32'h00008001},
         {2'b11, 7'h08, 1'b0, 32'h80013344},
         {2'b01, 7'h08, 1'b1, 32'h00003344},
         {2'b00, 7'h0B, 1'b1, 32'hFFFFFF80}};
      store(2'b11, 7'h08, 32'h11223344);
      for (int i = 0; i < 4; i++) begin
         i_access_size = vec_a[i][41:40];
         i_addr        = vec_a[i][39:33];
         i_sign_ext    = vec_a[i][32];
         #1;
         tests++;
         if (o_data !== vec_a[i][31:0]) begin
            fails++;
            $display("FAIL load_a%0d: got %h expected %h", i, o_data, vec_a[i][31:0]);
         end
      end
      store(2'b01, 7'h0A, 32'h00008001);
      for (int i = 0; i < 5; i++) begin
         i_access_size = vec_b[i][41:40];
         i_addr        = vec_b[i][39:33];
         i_sign_ext    = vec_b[i][32];
         #1;
         tests++;
         if (o_data !== vec_b[i][31:0]) begin
            fails++;
            $display("FAIL load_b%0d: got %h expected %h", i, o_data, vec_b[i][31:0]);
         end
      end
      model[2] = 32'h80013344;
   endtask

   task automatic test_misaligned();
      store(2'b11, 7'h04, 32'hAABBCCDD);
      // sh to 0x05
      i_access_size = 2'b01; i_addr = 7'h05; i_data = 32'h00001234; i_wr = 1'b1;
      #1;
      tests++;
      if (o_misaligned !== 1'b1) begin
         fails++;
         $display("FAIL mis_sh05: got %b expected 1", o_misaligned);
      end
      tick();
      // sw to 0x06
      i_access_size = 2'b11; i_addr = 7'h06; i_data = 32'hDEADBEEF;
      #1;
      tests++;
      if (o_misaligned !== 1'b1) begin
         fails++;
         $display("FAIL mis_sw06: got %b expected 1", o_misaligned);
      end
      tick();
      i_wr = 1'b0;
      // reserved size, no store request
      i_access_size = 2'b10; i_addr = 7'h06;
      #1;
      tests++;
      if (o_misaligned !== 1'b1) begin
         fails++;
         $display("FAIL mis_rsv06: got %b expected 1", o_misaligned);
      end
      i_access_size = 2'b11; i_addr = 7'h04; i_sign_ext = 1'b0;
      #1;
      tests++;
      if (o_data !== 32'hAABBCCDD) begin
         fails++;
         $display("FAIL mis_unchanged: got %h expected aabbccdd", o_data);
      end
      // sb to 0x07
      i_access_size = 2'b00; i_addr = 7'h07; i_data = 32'h00000055; i_wr = 1'b1;
      #1;
      tests++;
      if (o_misaligned !== 1'b0) begin
         fails++;
         $display("FAIL mis_sb07: got %b expected 0", o_misaligned);
      end
      tick();
      i_wr = 1'b0;
      i_access_size = 2'b11; i_addr = 7'h04;
      #1;
      tests++;
      if (o_data !== 32'h55BBCCDD) begin
         fails++;
         $display("FAIL sb07_word: got %h expected 55bbccdd", o_data);
      end
      i_access_size = 2'b01; i_addr = 7'h05; i_sign_ext = 1'b1;
      #1;
      tests++;
      if (o_data !== 32'hFFFFCCDD) begin
         fails++;
         $display("FAIL mis_lh05: got %h expected ffffccdd", o_data);
      end
      i_access_size = 2'b00; i_addr = 7'h05; i_sign_ext = 1'b0;
      #1;
      tests++;
      if (o_data !== 32'h000000CC || o_misaligned !== 1'b0) begin
         fails++;
         $display("FAIL lbu05: got %h mis=%b expected 000000cc mis=0", o_data, o_misaligned);
      end
      model[1] = 32'h55BBCCDD;
   endtask

   task automatic test_dump_toggle();
      store(2'b11, 7'h7C, 32'hCAFEF00D);
      model[31] = 32'hCAFEF00D;
      dump_check(1'b1, 1, "dump_toggle");
   endtask

   task automatic test_flush_dump();
      int busy_cnt;
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      i_dump_ready = 1'b1;
      repeat (10) tick();
      i_dump_ready = 1'b0;
      tests++;
      if (o_dump_valid !== 1'b1 || o_dump_data !== model[10]) begin
         fails++;
         $display("FAIL flush_pre: got valid=%b data=%h expected 1 %h", o_dump_valid, o_dump_data, model[10]);
      end
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      tests++;
      if (o_dump_valid !== 1'b0 || o_busy !== 1'b1) begin
         fails++;
         $display("FAIL flush_abort: got valid=%b busy=%b expected 0 1", o_dump_valid, o_busy);
      end
      busy_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         if (o_busy !== 1'b1) break;
         if (o_dump_valid !== 1'b0) break;
         busy_cnt++;
         tick();
      end
      tests++;
      if (busy_cnt != 32) begin
         fails++;
         $display("FAIL flush_sweep_len: got %0d busy cycles, expected 32", busy_cnt);
      end
      i_access_size = 2'b11;
      for (int w = 0; w < 32; w++) begin
         i_addr = 7'(w * 4);
         #1;
         tests++;
         if (o_data !== 32'h00000000) begin
            fails++;
            $display("FAIL flush_zero word %0d: got %h expected 00000000", w, o_data);
         end
         model[w] = 32'h00000000;
      end
   endtask

   task automatic test_store_in_clear();
      int n;
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      repeat (3) tick();
      store(2'b11, 7'h00, 32'h12345678);
      n = 0;
      while (o_busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      tests++;
      if (o_busy !== 1'b0) begin
         fails++;
         $display("FAIL clear_timeout: got busy=%b expected 0", o_busy);
      end
      i_access_size = 2'b11; i_addr = 7'h00;
      #1;
      tests++;
      if (o_data !== 32'h00000000) begin
         fails++;
         $display("FAIL store_in_clear: got %h expected 00000000", o_data);
      end
   endtask

   task automatic test_back_to_back();
      i_access_size = 2'b11; i_addr = 7'h0C; i_data = 32'h0BADF00D;
      i_wr = 1'b1; i_dump_start = 1'b1;
      tick();
      i_wr = 1'b0; i_dump_start = 1'b0;
      model[3] = 32'h0BADF00D;
      dump_check(1'b0, 0, "store_and_dump");
      i_addr = 7'h0C;
      #1;
      tests++;
      if (o_data !== 32'h0BADF00D) begin
         fails++;
         $display("FAIL b2b_word: got %h expected 0badf00d", o_data);
      end
   endtask

   initial begin
      i_reset = 1'b1; i_flush = 1'b0; i_wr = 1'b0; i_access_size = 2'b11;
      i_sign_ext = 1'b0; i_addr = 7'h00; i_data = 32'h00000000;
      i_dump_start = 1'b0; i_dump_ready = 1'b0;
      test_reset();
      test_loads();
      test_misaligned();
      test_dump_toggle();
      test_flush_dump();
      test_store_in_clear();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/byte_data_memory.md
# byte_data_memory

Byte-addressable MIPS data memory, the successor to the word-only data memory in the MEM stage. It supports byte, halfword and word loads and stores, sign or zero extension, and misalignment detection. It clears its contents with a sequenced sweep instead of a single-cycle clear. A valid/ready dump port streams the contents to the debug unit word by word, replacing the flat debug bus.

## Interface
Parameters:
- ADDR_SIZE, default 5: word-address width; depth = 2**ADDR_SIZE words; byte address is ADDR_SIZE+2 bits.
- WORD_SIZE, default 32: word width; fixed at 32 for MIPS, and any other value is unsupported.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_reset, input, 1: reset i_reset, synchronous, active-high; clock i_clk.
- i_flush, input, 1: start a clear sweep (same effect as reset on memory contents).
- i_wr, input, 1: store request.
- i_access_size, input, 2: 00 byte, 01 halfword, 11 word, 10 reserved (treated as word).
- i_sign_ext, input, 1: 1 = sign-extend sub-word loads, 0 = zero-extend.
- i_addr, input, ADDR_SIZE+2: byte address; [ADDR_SIZE+1:2] selects the word, [1:0] selects the lane.
- i_data, input, 32: store data; the byte/half value sits in the low bits.
- o_data, output, 32: load data, extended.
- o_misaligned, output, 1: the current access is misaligned.
- o_busy, output, 1: a clear or dump is in progress; the pipeline must stall memory ops.
- i_dump_start, input, 1: begin a dump.
- o_dump_data, output, 32: word at the current dump index.
- o_dump_valid, output, 1: o_dump_data is valid.
- i_dump_ready, input, 1: the consumer accepts the word.
- o_dump_last, output, 1: the current dump word is the final one (index 2**ADDR_SIZE-1).

## Operation
- Lanes are little-endian. Lane 0 is bits [7:0]. A halfword at addr[1]=0 is bits [15:0], and at addr[1]=1 it is bits [31:16].
- Misalignment:
  - halfword with addr[0]=1;
  - word/reserved with addr[1:0]!=0;
  - byte is never misaligned.
  - o_misaligned is combinational and independent of i_wr and of state.
- Store, in IDLE only, when i_wr=1 and o_misaligned=0:
  - only the addressed lanes are written; the other bytes of the word are unchanged.
  - Stores in CLEAR/DUMP, or misaligned stores, are dropped with no memory change.
- Load: o_data is combinational from the addressed word in every state.
  - Byte: extend bit 7 of the lane (i_sign_ext=1) or zero-fill.
  - Halfword: same rule on bit 15.
  - Word: unmodified.
  - A misaligned load returns the extension of the lane-aligned-down value; the pipeline raises the exception from o_misaligned.
- States:
  - IDLE: o_busy=0.
  - CLEAR: writes 0 to word idx each cycle, idx++. After writing word 2**ADDR_SIZE-1 it goes to IDLE.
  - DUMP: o_dump_valid=1 and o_dump_data=mem[idx]. When i_dump_ready=1, idx++. The transfer with o_dump_last=1 returns to IDLE.
- Transitions and priority, highest first:
  1. i_reset: state=CLEAR, idx=0.
  2. i_flush: CLEAR, idx=0, from any state. A dump in progress aborts with no further valid words; i_flush during CLEAR restarts at idx 0.
  3. i_dump_start in IDLE: DUMP, idx=0. It is ignored in CLEAR and DUMP.
- A store and i_dump_start in the same IDLE cycle: the store commits, and the dump (starting next cycle) sees the new data.
- o_dump_data and o_dump_last are held stable while o_dump_valid=1 and i_dump_ready=0.

## Timing
- During and immediately after reset: o_busy=1, o_dump_valid=0, o_dump_last=0, state=CLEAR, idx=0.
  - o_data and o_misaligned are combinational from the inputs and memory.
- Clear sweep: exactly 2**ADDR_SIZE cycles after reset/flush deasserts, with one word cleared per edge. o_busy falls on the edge that clears the last word.
- Store latency: commits on the rising edge where i_wr=1. A load of the same address in the following cycle returns the new value.
- Load latency: 0 cycles (combinational).
- Dump:
  - o_dump_valid rises the cycle after i_dump_start is sampled.
  - One word per cycle with i_dump_ready held high, so the minimum dump is 2**ADDR_SIZE cycles.
  - o_dump_valid and o_busy fall after the last handshake edge.
- idx width is ADDR_SIZE bits. The terminal index is detected explicitly, with no reliance on wrap-around.

## Test plan
- Reset then idle for 2**ADDR_SIZE=32 cycles: o_busy=1 for exactly 32 cycles after reset release, then 0. A dump returns 32 words of 0x00000000 with o_dump_last only on the 32nd.
- sw 0x11223344 to addr 0x08, then lb addr 0x0B with sign_ext=0: returns 0x00000011. lh addr 0x0A with sign_ext=1 after sh 0x8001 to 0x0A: returns 0xFFFF8001 while word 0x08 reads 0x80013344.
- sh to addr 0x05 and sw to addr 0x06: o_misaligned=1, memory unchanged. sb to 0x07: o_misaligned=0 and only bits [31:24] change.
- Dump with i_dump_ready toggling 1,0,0,1…: each word is held stable while ready=0, no word is skipped or repeated, and the word order is 0..31.
- i_flush asserted at dump index 10: o_dump_valid=0 next cycle, a 32-cycle clear follows, and memory reads all zero.
- sw during CLEAR with i_wr=1: dropped, and the word reads 0 after the sweep completes. sw plus i_dump_start in the same IDLE cycle: the dump contains the stored value.
